reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised general-purpose register file for the multi-cycle CPU: 2 async read ports, 1 sync write port.
//  Optional hardwired-zero R0 and write-to-read bypass.
//  Per-register busy scoreboard: the control FSM sets a bit at issue; the write-back clears it.
//  Handshaked debug dump engine streams every register out one per accepted beat.
// PARAMETERS
//  DATA_W    16  register width in bits
//  ADDR_W    3   address width; DEPTH = 2**ADDR_W registers
//  ZERO_REG  1   1: R0 reads 0, ignores writes, never busy; 0: R0 is an ordinary register
//  BYPASS    1   1: read port returns same-cycle write data on address match; 0: returns stored value
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  we          in   1       write enable
//  waddr       in   ADDR_W  write address
//  wdata       in   DATA_W  write data
//  raddr1      in   ADDR_W  read port 1 address
//  raddr2      in   ADDR_W  read port 2 address
//  rdata1      out  DATA_W  read port 1 data (combinational)
//  rdata2      out  DATA_W  read port 2 data (combinational)
//  rbusy1      out  1       raddr1 has a pending write (combinational)
//  rbusy2      out  1       raddr2 has a pending write (combinational)
//  sb_set      in   1       mark sb_addr busy (instruction issued)
//  sb_addr     in   ADDR_W  scoreboard set address
//  dump_start  in   1       request full register dump
//  dump_valid  out  1       dump beat valid
//  dump_ready  in   1       consumer accepts beat
//  dump_addr   out  ADDR_W  register index of current beat
//  dump_data   out  DATA_W  register contents of current beat
//  dump_done   out  1       one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (async): all registers 0, busy vector 0, FSM IDLE, dump_idx 0; dump_valid=0, dump_done=0, dump_addr=0.
//  Write: at posedge, if we and not (ZERO_REG and waddr==0): reg[waddr]<=wdata; busy[waddr]<=0.
//  Scoreboard: at posedge, if sb_set and not (ZERO_REG and sb_addr==0): busy[sb_addr]<=1.
//   - Set and write-back clear on the same address in the same cycle: set wins, bit ends 1.
//  Read: rdataN = 0 if ZERO_REG and raddrN==0.
//   - Else if BYPASS and we and waddr==raddrN: rdataN = wdata.
//   - Else: rdataN = reg[raddrN].
//  Busy read: rbusyN = 0 if ZERO_REG and raddrN==0.
//   - Else if BYPASS and we and waddr==raddrN and not (sb_set and sb_addr==raddrN): rbusyN = 0.
//   - Else: rbusyN = busy[raddrN].
//  Both read ports are independent; same address on both ports gives identical outputs.
//  Dump FSM, states IDLE, DUMP, DONE:
//   IDLE: dump_start -> DUMP, dump_idx<=0.
//   DUMP: dump_valid=1, dump_addr=dump_idx, dump_data=reg[dump_idx] (zero-masked per ZERO_REG, no bypass).
//    - valid and ready, idx==DEPTH-1 -> DONE.
//    - valid and ready, otherwise -> idx+1.
//    - no ready: hold all dump outputs stable.
//   DONE: dump_done=1 for one cycle -> IDLE; dump_valid=0.
//  dump_start is ignored outside IDLE.
//  Writes during a dump are allowed; a beat shows the contents current in the cycle it is presented.
//  Reset mid-dump: immediate return to IDLE, no dump_done.
//  Latency: read 0 cycles; write visible to reads next cycle (same cycle with BYPASS).
//  Dump: DEPTH accepted beats, then dump_done in the following cycle.
// TESTING
//  1 reset; we=1,waddr=3,wdata=16'hBEEF; next cycle raddr1=3 -> rdata1=16'hBEEF; raddr2=5 -> rdata2=0.
//  2 ZERO_REG=1: we=1,waddr=0,wdata=16'h1234; sb_set=1,sb_addr=0 -> rdata1(raddr1=0)=0, rbusy1=0.
//  3 BYPASS=1: same cycle we=1,waddr=2,wdata=16'h00A5, raddr1=2 -> rdata1=16'h00A5 before the edge.
//  4 sb_set addr 4 -> rbusy1(raddr1=4)=1; later we to 4 -> rbusy=0; set+write to 4 in one cycle -> rbusy=1 next cycle.
//  5 regs = index*16'h0101; dump_start, dump_ready toggled 1/0 -> 8 beats, addr 0..7, data 0,16'h0101..16'h0707; dump_done once; valid stable while stalled.
//  6 reset asserted at beat 3 of a dump -> dump_valid=0 immediately, all regs 0, no dump_done; new dump_start restarts at addr 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// General-purpose register file: two combinational read ports, one synchronous write port,
// per-register busy scoreboard and a ready/valid debug dump engine.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    dump_state_t       state_r;
    logic [ADDR_W-1:0] dump_idx_r;
    logic              dump_valid_r;
    logic              dump_done_r;

    logic              wr_ok_s;
    logic              set_ok_s;
    logic [DATA_W-1:0] rdata1_s;
    logic [DATA_W-1:0] rdata2_s;
    logic              rbusy1_s;
    logic              rbusy2_s;
    logic [DATA_W-1:0] dump_data_s;

    // R0 is write-protected and never busy when hardwired to zero
    assign wr_ok_s  = we && !((ZERO_REG != 0) && (waddr == ZERO_ADDR));
    assign set_ok_s = sb_set && !((ZERO_REG != 0) && (sb_addr == ZERO_ADDR));

    // Register array storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (wr_ok_s) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Busy scoreboard; the set is applied last so it wins over a same-cycle write-back clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_ok_s) begin
                busy_r[waddr] <= 1'b0;
            end
            if (set_ok_s) begin
                busy_r[sb_addr] <= 1'b1;
            end
        end
    end

    // Read port 1 data and busy, with optional write bypass
    always_comb begin
        rdata1_s = regs_r[raddr1];
        rbusy1_s = busy_r[raddr1];
        if ((ZERO_REG != 0) && (raddr1 == ZERO_ADDR)) begin
            rdata1_s = ZERO_DATA;
            rbusy1_s = 1'b0;
        end else if ((BYPASS != 0) && we && (waddr == raddr1)) begin
            rdata1_s = wdata;
            rbusy1_s = (sb_set && (sb_addr == raddr1)) ? busy_r[raddr1] : 1'b0;
        end else begin
            rdata1_s = regs_r[raddr1];
            rbusy1_s = busy_r[raddr1];
        end
    end

    // Read port 2 data and busy, with optional write bypass
    always_comb begin
        rdata2_s = regs_r[raddr2];
        rbusy2_s = busy_r[raddr2];
        if ((ZERO_REG != 0) && (raddr2 == ZERO_ADDR)) begin
            rdata2_s = ZERO_DATA;
            rbusy2_s = 1'b0;
        end else if ((BYPASS != 0) && we && (waddr == raddr2)) begin
            rdata2_s = wdata;
            rbusy2_s = (sb_set && (sb_addr == raddr2)) ? busy_r[raddr2] : 1'b0;
        end else begin
            rdata2_s = regs_r[raddr2];
            rbusy2_s = busy_r[raddr2];
        end
    end

    // Dump beat data tracks the stored contents live, without bypass
    always_comb begin
        if ((ZERO_REG != 0) && (dump_idx_r == ZERO_ADDR)) begin
            dump_data_s = ZERO_DATA;
        end else begin
            dump_data_s = regs_r[dump_idx_r];
        end
    end

    // Dump engine state machine with registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            dump_idx_r   <= ZERO_ADDR;
            dump_valid_r <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    dump_done_r <= 1'b0;
                    if (dump_start) begin
                        state_r      <= DUMP;
                        dump_idx_r   <= ZERO_ADDR;
                        dump_valid_r <= 1'b1;
                    end else begin
                        dump_valid_r <= 1'b0;
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        if (dump_idx_r == LAST_IDX) begin
                            state_r      <= DONE;
                            dump_valid_r <= 1'b0;
                            dump_done_r  <= 1'b1;
                        end else begin
                            dump_idx_r <= dump_idx_r + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    dump_valid_r <= 1'b0;
                    dump_done_r  <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    dump_valid_r <= 1'b0;
                    dump_done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata1     = rdata1_s;
    assign rdata2     = rdata2_s;
    assign rbusy1     = rbusy1_s;
    assign rbusy2     = rbusy2_s;
    assign dump_valid = dump_valid_r;
    assign dump_addr  = dump_idx_r;
    assign dump_data  = dump_data_s;
    assign dump_done  = dump_done_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb: reset, write/read, R0, bypass,
// scoreboard and dump engine including reset in the middle of a dump.
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr1;
    logic [2:0]  raddr2;
    logic [15:0] rdata1;
    logic [15:0] rdata2;
    logic        rbusy1;
    logic        rbusy2;
    logic        sb_set;
    logic [2:0]  sb_addr;
    logic        dump_start;
    logic        dump_valid;
    logic        dump_ready;
    logic [2:0]  dump_addr;
    logic [15:0] dump_data;
    logic        dump_done;

    int errors = 0;
    int checks = 0;

    reg_file_sb #(
        .DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .reset(reset),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        we = 1'b0; waddr = 3'd0; wdata = 16'h0000;
        sb_set = 1'b0; sb_addr = 3'd0;
        dump_start = 1'b0; dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        raddr1 = 3'd3; raddr2 = 3'd5;
        reset = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", dump_valid); end
        checks++; if (dump_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", dump_done); end
        checks++; if (dump_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d required 0", dump_addr); end
        checks++; if (rdata1 !== 16'h0000) begin errors++; $display("FAIL reset_rdata1: got %h required 0000", rdata1); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL reset_rbusy1: got %b required 0", rbusy1); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
        raddr1 = 3'd1; raddr2 = 3'd5;
        @(negedge clk);
        we = 1'b0;
        raddr1 = 3'd3; raddr2 = 3'd5;
        #1;
        checks++; if (rdata1 !== 16'hBEEF) begin errors++; $display("FAIL wr_rdata1: got %h required beef", rdata1); end
        checks++; if (rdata2 !== 16'h0000) begin errors++; $display("FAIL wr_rdata2: got %h required 0000", rdata2); end
        raddr2 = 3'd3; #1;
        checks++; if (rdata2 !== 16'hBEEF) begin errors++; $display("FAIL wr_same_addr: got %h required beef", rdata2); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1; waddr = 3'd0; wdata = 16'h1234;
        sb_set = 1'b1; sb_addr = 3'd0;
        raddr1 = 3'd0;
        #1;
        checks++; if (rdata1 !== 16'h0000) begin errors++; $display("FAIL zero_bypass: got %h required 0000", rdata1); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL zero_busy_now: got %b required 0", rbusy1); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (rdata1 !== 16'h0000) begin errors++; $display("FAIL zero_stored: got %h required 0000", rdata1); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL zero_busy_next: got %b required 0", rbusy1); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; waddr = 3'd2; wdata = 16'h00A5;
        raddr1 = 3'd2; raddr2 = 3'd2;
        #1;
        checks++; if (rdata1 !== 16'h00A5) begin errors++; $display("FAIL bypass_rdata1: got %h required 00a5", rdata1); end
        checks++; if (rdata2 !== 16'h00A5) begin errors++; $display("FAIL bypass_rdata2: got %h required 00a5", rdata2); end
        @(negedge clk);
        we = 1'b0; #1;
        checks++; if (rdata1 !== 16'h00A5) begin errors++; $display("FAIL bypass_stored: got %h required 00a5", rdata1); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 3'd4;
        @(negedge clk);
        sb_set = 1'b0;
        raddr1 = 3'd4; raddr2 = 3'd5; #1;
        checks++; if (rbusy1 !== 1'b1) begin errors++; $display("FAIL sb_set: got %b required 1", rbusy1); end
        checks++; if (rbusy2 !== 1'b0) begin errors++; $display("FAIL sb_other: got %b required 0", rbusy2); end
        we = 1'b1; waddr = 3'd4; wdata = 16'h4444; #1;
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL sb_bypass_clear: got %b required 0", rbusy1); end
        @(negedge clk);
        we = 1'b0; #1;
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b required 0", rbusy1); end
        checks++; if (rdata1 !== 16'h4444) begin errors++; $display("FAIL sb_wb_data: got %h required 4444", rdata1); end
        we = 1'b1; waddr = 3'd4; wdata = 16'h4545;
        sb_set = 1'b1; sb_addr = 3'd4; #1;
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL sb_both_now: got %b required 0", rbusy1); end
        @(negedge clk);
        idle_inputs(); #1;
        checks++; if (rbusy1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b required 1", rbusy1); end
        checks++; if (rdata1 !== 16'h4545) begin errors++; $display("FAIL sb_both_data: got %h required 4545", rdata1); end
    endtask

    task automatic test_dump();
        int beats = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        int last_acc = -10;
        bit finished = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = 3'(i); wdata = 16'(i * 257);
        end
        @(negedge clk);
        idle_inputs();
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            dump_ready = (cyc % 2 == 0);
            #1;
            if (dump_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dump_valid && beats >= 8) begin
                checks++; errors++;
                $display("FAIL dump_extra_beat: got valid at addr %0d required no beat", dump_addr);
            end else if (dump_valid) begin
                checks++; if (dump_addr !== 3'(beats)) begin errors++; $display("FAIL dump_addr: got %0d required %0d", dump_addr, beats); end
                checks++; if (dump_data !== 16'(beats * 257)) begin errors++; $display("FAIL dump_data: got %h required %h", dump_data, 16'(beats * 257)); end
                if (dump_ready) begin
                    last_acc = cyc;
                    beats++;
                end
            end else if (beats < 8) begin
                checks++; errors++;
                $display("FAIL dump_valid_drop: got 0 at beat %0d required 1", beats);
            end
            if (done_cnt > 0 && cyc > done_cyc + 2) finished = 1'b1;
            @(negedge clk);
        end
        dump_ready = 1'b0;
        checks++; if (beats !== 8) begin errors++; $display("FAIL dump_beats: got %0d required 8", beats); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL dump_done_count: got %0d required 1", done_cnt); end
        checks++; if (done_cyc !== last_acc + 1) begin errors++; $display("FAIL dump_done_timing: got cycle %0d required %0d", done_cyc, last_acc + 1); end
    endtask

    task automatic test_reset_mid_dump();
        bit hit = 1'b0;
        bit saw_done = 1'b0;
        @(negedge clk);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        dump_ready = 1'b1;
        for (int k = 0; k < 20 && !hit; k++) begin
            #1;
            if (dump_valid && dump_addr == 3'd3) hit = 1'b1;
            else @(negedge clk);
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_reach_beat3: got %b required 1", hit); end
        reset = 1'b1;
        raddr1 = 3'd5; raddr2 = 3'd7;
        #1;
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b required 0", dump_valid); end
        checks++; if (dump_addr !== 3'd0) begin errors++; $display("FAIL mid_addr: got %0d required 0", dump_addr); end
        checks++; if (rdata1 !== 16'h0000) begin errors++; $display("FAIL mid_reg5: got %h required 0000", rdata1); end
        checks++; if (rdata2 !== 16'h0000) begin errors++; $display("FAIL mid_reg7: got %h required 0000", rdata2); end
        dump_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) reset = 1'b0;
            #1;
            if (dump_done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b required 0", saw_done); end
        @(negedge clk);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0; #1;
        checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL restart_valid: got %b required 1", dump_valid); end
        checks++; if (dump_addr !== 3'd0) begin errors++; $display("FAIL restart_addr: got %0d required 0", dump_addr); end
        dump_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (dump_data !== 16'h0000) begin errors++; $display("FAIL restart_data1: got %h required 0000", dump_data); end
        for (int k = 0; k < 20 && !saw_done; k++) begin
            @(negedge clk); #1;
            if (dump_done) saw_done = 1'b1;
        end
        dump_ready = 1'b0;
        checks++; if (saw_done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b required 1", saw_done); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_dump();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
